// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing helper for the bit counter.
package serial_subtractor_pkg;

  // Controller states: waiting, shifting one bit per cycle, result pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of a counter that must reach WIDTH-1, i.e. ceil(log2(WIDTH)),
  // never narrower than one bit
  function automatic int cntWidth(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of all three inputs
  assign d = a ^ b ^ bin;

  // Borrow out when b exceeds a, or when a equals b and a borrow comes in
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes D = A - B - Bin one bit per clock, LSB
// first, through a single full-subtractor cell. A start/busy/done handshake
// frames each operation; the outputs only change when a result completes.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             bOut_q, bOut_d;
  logic             vOut_q, vOut_d;

  logic             fsDiff;
  logic             fsBorrow;
  logic             acceptStart;

  // The one arithmetic cell, fed by the LSBs of the operand shifters
  full_subtractor u_fs (
    .a    (aReg_q[0]),
    .b    (bReg_q[0]),
    .bin  (borrow_q),
    .d    (fsDiff),
    .bout (fsBorrow)
  );

  // Requests are only honoured when no operation is in flight
  assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state and datapath update; registers hold unless the state says otherwise
  always_comb begin
    state_d  = state_q;
    aReg_d   = aReg_q;
    bReg_d   = bReg_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    dOut_d   = dOut_q;
    bOut_d   = bOut_q;
    vOut_d   = vOut_q;

    case (state_q)
      IDLE, DONE: begin
        if (acceptStart) begin
          state_d  = SHIFT;
          aReg_d   = A;
          bReg_d   = B;
          borrow_d = Bin;
          cnt_d    = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        aReg_d   = aReg_q >> 1;
        bReg_d   = bReg_q >> 1;
        res_d    = {fsDiff, res_q[WIDTH-1:1]};
        borrow_d = fsBorrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          dOut_d  = {fsDiff, res_q[WIDTH-1:1]};
          bOut_d  = fsBorrow;
          vOut_d  = borrow_q ^ fsBorrow;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aReg_q   <= '0;
      bReg_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      dOut_q   <= '0;
      bOut_q   <= 1'b0;
      vOut_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aReg_q   <= aReg_d;
      bReg_q   <= bReg_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      dOut_q   <= dOut_d;
      bOut_q   <= bOut_d;
      vOut_q   <= vOut_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign D    = dOut_q;
  assign Bout = bOut_q;
  assign V    = vOut_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): a table of
// hand-computed subtractions run through the handshake, plus directed
// sequences for start-while-busy and reset in the middle of an operation.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  int testCount = 0;
  int failCount = 0;

  logic [WIDTH-1:0] lastD;
  logic             lastBout;
  logic             lastV;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] expD;
    logic             expBout;
    logic             expV;
    bit               backToBack;
    string            name;
  } vector_t;

  vector_t vectors[7];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .V     (V)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log any miss
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance past the next rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs so
  // any late re-capture shows up in the result
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin);
    A     = a;
    B     = b;
    Bin   = bin;
    start = 1'b1;
    step();
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    Bin   = ~bin;
  endtask

  // Full operation: busy for WIDTH cycles with outputs held, then one done
  // cycle carrying the new result; optionally confirm the pulse ends
  task automatic runOp(input vector_t v);
    applyStimulus(v.a, v.b, v.bin);
    for (int k = 1; k <= WIDTH; k++) begin
      checkOutput({v.name, " busy"}, {24'd0, busy, done, D, Bout, V},
                  {24'd0, 1'b1, 1'b0, lastD, lastBout, lastV});
      step();
    end
    checkOutput({v.name, " done"}, {24'd0, busy, done, D, Bout, V},
                {24'd0, 1'b0, 1'b1, v.expD, v.expBout, v.expV});
    lastD    = v.expD;
    lastBout = v.expBout;
    lastV    = v.expV;
    if (!v.backToBack) begin
      step();
      checkOutput({v.name, " hold"}, {24'd0, busy, done, D, Bout, V},
                  {24'd0, 1'b0, 1'b0, lastD, lastBout, lastV});
    end
  endtask

  // Main sequence: reset/idle, vector table, then directed corner cases
  initial begin
    int doneCnt;
    int doneCyc;
    int cyc;
    logic [WIDTH-1:0] capD;
    logic capBout;
    logic capV;
    vector_t tail;

    vectors[0] = '{4'b0100, 4'b1000, 1'b0, 4'b1100, 1'b1, 1'b1, 1'b0, "basic"};
    vectors[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "borrowIn"};
    vectors[2] = '{4'b0101, 4'b1010, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, "b2bFirst"};
    vectors[3] = '{4'b1101, 4'b0111, 1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, "b2bSecond"};
    vectors[4] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, "zeroMinusBin"};
    vectors[5] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, "posOverflow"};
    vectors[6] = '{4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, "negOverflow"};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    lastD    = '0;
    lastBout = 1'b0;
    lastV    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("resetIdle", {24'd0, busy, done, D, Bout, V}, 32'd0);
      step();
    end

    for (int i = 0; i < 7; i++) begin
      runOp(vectors[i]);
    end

    // A second start two cycles into an operation must be ignored
    applyStimulus(4'b0011, 4'b0001, 1'b0);
    step();
    A     = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    doneCnt = 0;
    doneCyc = 0;
    capD    = '0;
    capBout = 1'b0;
    capV    = 1'b0;
    cyc     = 3;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          doneCyc = cyc;
          capD    = D;
          capBout = Bout;
          capV    = V;
        end
      end
      step();
      cyc++;
    end
    checkOutput("busyStart doneCount", doneCnt, 1);
    checkOutput("busyStart doneCycle", doneCyc, 5);
    checkOutput("busyStart result", {28'd0, capD, capBout, capV},
                {28'd0, 4'b0010, 1'b0, 1'b0});
    lastD    = 4'b0010;
    lastBout = 1'b0;
    lastV    = 1'b0;

    // Reset during the second SHIFT cycle clears everything, no done follows
    applyStimulus(4'b0100, 4'b1000, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midReset cleared", {24'd0, busy, done, D, Bout, V}, 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) doneCnt++;
      step();
    end
    checkOutput("midReset noDone", doneCnt, 0);
    checkOutput("midReset stillClear", {24'd0, busy, done, D, Bout, V}, 32'd0);
    lastD    = '0;
    lastBout = 1'b0;
    lastV    = 1'b0;

    tail = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, "afterReset"};
    runOp(tail);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
